// File: rtl/cpuc_cmp_seq.sv
// cpuc_cmp_seq: multi-mode comparator (EQ/NE/LT/GE, signed/unsigned) that walks the operands
// MSB-first, CHUNK_WIDTH bits per clock. Define CPUC_CMP_EARLY_EXIT_EN to finish at the first differing chunk.
module cpuc_cmp_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHUNK_WIDTH = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [2:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_eq,
    output logic                  out_lt,
    output logic                  out_err
);

    localparam int N      = DATA_WIDTH / CHUNK_WIDTH;
    localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

    localparam logic [2:0] MODE_EQ  = 3'd0;
    localparam logic [2:0] MODE_NE  = 3'd1;
    localparam logic [2:0] MODE_LT  = 3'd2;
    localparam logic [2:0] MODE_GE  = 3'd3;
    localparam logic [2:0] MODE_LTU = 3'd4;
    localparam logic [2:0] MODE_GEU = 3'd5;

    generate
        if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_chunk
            $error("cpuc_cmp_seq: CHUNK_WIDTH must divide DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [2:0]              mode_q, mode_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic                    resolved_q, resolved_d;
    logic                    a_lt_q, a_lt_d;

    logic [CHUNK_WIDTH-1:0]  chunk_a;
    logic [CHUNK_WIDTH-1:0]  chunk_b;
    logic                    chunk_diff;
    logic                    signed_mode;
    logic [DATA_WIDTH-1:0]   msb_flip;
    logic                    relation;
    logic                    reserved_mode;

    // Operands are shifted left each step, so the chunk under test always sits at the top.
    assign chunk_a     = a_q[DATA_WIDTH-1 -: CHUNK_WIDTH];
    assign chunk_b     = b_q[DATA_WIDTH-1 -: CHUNK_WIDTH];
    assign chunk_diff  = !resolved_q && (chunk_a != chunk_b);
    assign signed_mode = (mode == MODE_LT) || (mode == MODE_GE);
    assign msb_flip    = {signed_mode, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        step_d     = step_q;
        resolved_d = resolved_q;
        a_lt_d     = a_lt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Offset-binary on signed modes lets the chunk compare stay unsigned.
                    a_d        = data_in1 ^ msb_flip;
                    b_d        = data_in2 ^ msb_flip;
                    mode_d     = mode;
                    step_d     = '0;
                    resolved_d = 1'b0;
                    a_lt_d     = 1'b0;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                a_d = a_q << CHUNK_WIDTH;
                b_d = b_q << CHUNK_WIDTH;
                if (step_q != LAST_STEP) begin
                    step_d = step_q + 1'b1;
                end
                if (chunk_diff) begin
                    resolved_d = 1'b1;
                    a_lt_d     = chunk_a < chunk_b;
                end
                if (step_q == LAST_STEP) begin
                    state_d = S_DONE;
                end
`ifdef CPUC_CMP_EARLY_EXIT_EN
                if (chunk_diff) begin
                    state_d = S_DONE;
                end
`else
`endif
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= '0;
            step_q     <= '0;
            resolved_q <= 1'b0;
            a_lt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mode_q     <= mode_d;
            step_q     <= step_d;
            resolved_q <= resolved_d;
            a_lt_q     <= a_lt_d;
        end
    end

    // Result outputs are gated by DONE so they read zero everywhere else.
    always_comb begin
        relation      = 1'b0;
        reserved_mode = 1'b0;
        case (mode_q)
            MODE_EQ:  relation = !resolved_q;
            MODE_NE:  relation = resolved_q;
            MODE_LT:  relation = resolved_q && a_lt_q;
            MODE_GE:  relation = !(resolved_q && a_lt_q);
            MODE_LTU: relation = resolved_q && a_lt_q;
            MODE_GEU: relation = !(resolved_q && a_lt_q);
            default:  reserved_mode = 1'b1;
        endcase
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        data_out  = (out_valid && relation) ? '1 : '0;
        out_eq    = out_valid && !resolved_q;
        out_lt    = out_valid && resolved_q && a_lt_q;
        out_err   = out_valid && reserved_mode;
    end

endmodule
